cr_cddip_sa_sweep_ctrl: RTL and testbench



---
 rtl/cr_cddip_sa_sweep_ctrl_pkg.sv | 26 ++
 rtl/cr_cddip_sa_sweep_ctrl_if.sv | 23 ++
 rtl/cr_cddip_sa_sweep_tmr.sv | 24 ++
 rtl/cr_cddip_sa_sweep_ctrl.sv | 128 ++++++++++++
 tb/tb_cr_cddip_sa_sweep_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_cddip_sa_sweep_ctrl_pkg.sv
// Shared types and defaults for the stats-aggregator snapshot sweep controller.
package cr_cddip_sa_sweep_ctrl_pkg;

  localparam int unsigned DEF_N_CNT = 64;
  localparam int unsigned DEF_CNT_W = 50;
  localparam int unsigned DEF_TMR_W = 32;
  localparam int unsigned DEF_IDX_W = $clog2(DEF_N_CNT);
  localparam int unsigned DROP_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    SETTLE,
    READ,
    CAP,
    EMIT,
    DONE
  } sweep_state_e;

  typedef struct packed {
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_CNT_W-1:0] data;
    logic                 last;
  } sa_sweep_rec_t;

endpackage

// File: rtl/cr_cddip_sa_sweep_ctrl_if.sv
// Valid/ready record stream from the sweep controller to the downstream collector.
interface cr_cddip_sa_sweep_ctrl_if
  import cr_cddip_sa_sweep_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = DEF_IDX_W,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output out_valid, out_idx, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_idx, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/cr_cddip_sa_sweep_tmr.sv
// Free-running period timer; tmr_fire is high for one cycle every cfg_period cycles.
module cr_cddip_sa_sweep_tmr #(
  parameter int unsigned TMR_W = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [TMR_W-1:0] cfg_period,
  output logic             tmr_fire
);
  logic [TMR_W-1:0] tmr;

  // Using >= lets a period shortened on the fly fire at once instead of wrapping.
  assign tmr_fire = (cfg_period != '0) && (tmr >= cfg_period - TMR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (cfg_period == '0 || tmr_fire) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end
endmodule

// File: rtl/cr_cddip_sa_sweep_ctrl.sv
// Snapshot-and-readout sequencer: snap, settle, then stream {idx, value} records.
module cr_cddip_sa_sweep_ctrl
  import cr_cddip_sa_sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_CNT  = DEF_N_CNT,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned TMR_W  = DEF_TMR_W,
  parameter int unsigned SETTLE = 2,
  localparam int unsigned IDX_W = $clog2(N_CNT)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [TMR_W-1:0]   cfg_period,
  input  logic               cfg_clear_on_snap,
  input  logic               sw_trig,
  output logic               sa_snap,
  output logic               sa_clear_live,
  output logic [IDX_W-1:0]   rd_idx,
  input  logic [CNT_W-1:0]   rd_data,
  cr_cddip_sa_sweep_ctrl_if.master out_if,
  output logic               busy,
  output logic               done,
  output logic [DROP_W-1:0]  trig_drop_cnt
);
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // The SETTLE parameter shadows the imported state name, so alias it explicitly.
  localparam sweep_state_e ST_SETTLE = cr_cddip_sa_sweep_ctrl_pkg::SETTLE;

  sweep_state_e     state;
  logic [SET_W-1:0] settle_cnt;
  logic [IDX_W-1:0] idx;
  logic             tmr_fire;
  logic             trig;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [CNT_W-1:0] out_data_q;
  logic             out_last_q;

  cr_cddip_sa_sweep_tmr #(.TMR_W(TMR_W)) u_tmr (
    .clk        (clk),
    .rst        (rst),
    .cfg_period (cfg_period),
    .tmr_fire   (tmr_fire)
  );

  assign trig          = sw_trig | tmr_fire;
  assign busy          = (state != IDLE);
  assign sa_clear_live = sa_snap & cfg_clear_on_snap;

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      idx           <= '0;
      rd_idx        <= '0;
      sa_snap       <= 1'b0;
      done          <= 1'b0;
      trig_drop_cnt <= '0;
      out_valid_q   <= 1'b0;
      out_idx_q     <= '0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      sa_snap <= 1'b0;
      done    <= 1'b0;

      if (trig && state != IDLE && trig_drop_cnt != '1) begin
        trig_drop_cnt <= trig_drop_cnt + DROP_W'(1);
      end

      case (state)
        IDLE: begin
          if (trig) begin
            state   <= SNAP;
            sa_snap <= 1'b1;
          end
        end
        SNAP: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE - 1)) begin
            state  <= READ;
            idx    <= '0;
            rd_idx <= '0;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        READ: begin
          state <= CAP;
        end
        CAP: begin
          out_data_q  <= rd_data;
          out_idx_q   <= idx;
          out_last_q  <= (idx == IDX_W'(N_CNT - 1));
          out_valid_q <= 1'b1;
          state       <= EMIT;
        end
        EMIT: begin
          if (out_if.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx    <= idx + IDX_W'(1);
              rd_idx <= idx + IDX_W'(1);
              state  <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cr_cddip_sa_sweep_ctrl.sv
// Self-checking bench for cr_cddip_sa_sweep_ctrl against a timing/latency reference model.
module tb_cr_cddip_sa_sweep_ctrl;
  localparam int N_CNT  = 64;
  localparam int CNT_W  = 50;
  localparam int TMR_W  = 32;
  localparam int SETTLE = 2;
  localparam int IDX_W  = 6;
  // Negedge offset (after the accepting edge) at which done pulses; busy spans 0..D.
  localparam int D      = SETTLE + 3 * N_CNT + 1;

  logic             clk;
  logic             rst;
  logic [TMR_W-1:0] cfg_period;
  logic             cfg_clear_on_snap;
  logic             sw_trig;
  logic             sa_snap;
  logic             sa_clear_live;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [7:0]       trig_drop_cnt;

  logic [CNT_W-1:0] mem [N_CNT];
  logic [IDX_W-1:0] idx_d;

  int checks   = 0;
  int failures = 0;

  cr_cddip_sa_sweep_ctrl_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) oif ();

  cr_cddip_sa_sweep_ctrl #(
    .N_CNT  (N_CNT),
    .CNT_W  (CNT_W),
    .TMR_W  (TMR_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_period        (cfg_period),
    .cfg_clear_on_snap (cfg_clear_on_snap),
    .sw_trig           (sw_trig),
    .sa_snap           (sa_snap),
    .sa_clear_live     (sa_clear_live),
    .rd_idx            (rd_idx),
    .rd_data           (rd_data),
    .out_if            (oif.master),
    .busy              (busy),
    .done              (done),
    .trig_drop_cnt     (trig_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Snapshot RAM: data for the index presented in one cycle appears in the next.
  initial begin
    rd_data = '0;
    idx_d   = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_data = mem[idx_d];
      idx_d   = rd_idx;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    sw_trig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sa_snap, sa_clear_live, busy, done, oif.out_valid, oif.out_last} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000000",
               {sa_snap, sa_clear_live, busy, done, oif.out_valid, oif.out_last});
    end
    checks++;
    if ({rd_idx, oif.out_idx, trig_drop_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_idx got rd_idx=%0d out_idx=%0d drop=%0d exp all 0",
               rd_idx, oif.out_idx, trig_drop_cnt);
    end
    checks++;
    if (oif.out_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", oif.out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sa_snap, busy, done, oif.out_valid} !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0000", {sa_snap, busy, done, oif.out_valid});
    end
  endtask

  // Full sweep with out_ready=1: every event lands on a fixed offset from the trigger.
  task automatic test_sw_sweep(input logic clear);
    logic [4:0]       exp_ctl;
    logic             exp_valid;
    int               r;
    int               i;
    cfg_period        = '0;
    cfg_clear_on_snap = clear;
    oif.out_ready     = 1'b1;
    for (int k = 0; k < N_CNT; k++) mem[k] = CNT_W'({$urandom(), $urandom()});
    repeat (10) @(negedge clk);
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
    for (int m = 0; m <= D + 3; m++) begin
      if (m > 0) @(negedge clk);
      if (m == 1) cfg_clear_on_snap = ~clear;
      r         = m - 3 - SETTLE;
      exp_valid = (r >= 0) && (r % 3 == 0) && (r / 3 < N_CNT);
      exp_ctl   = {m == 0, (m == 0) && clear, m <= D, m == D, exp_valid};
      checks++;
      if ({sa_snap, sa_clear_live, busy, done, oif.out_valid} !== exp_ctl) begin
        failures++;
        $display("FAIL sweep_ctl m=%0d got=%b exp=%b", m,
                 {sa_snap, sa_clear_live, busy, done, oif.out_valid}, exp_ctl);
      end
      if (m == 1 + SETTLE) begin
        checks++;
        if (rd_idx !== '0) begin
          failures++;
          $display("FAIL sweep_first_rd_idx got=%0d exp=0", rd_idx);
        end
      end
      if (exp_valid) begin
        i = r / 3;
        checks++;
        if ({oif.out_idx, oif.out_data, oif.out_last} !==
            {IDX_W'(i), mem[i], i == N_CNT - 1}) begin
          failures++;
          $display("FAIL sweep_rec got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                   oif.out_idx, oif.out_data, oif.out_last, i, mem[i], i == N_CNT - 1);
        end
      end
    end
    cfg_clear_on_snap = 1'b0;
    checks++;
    if (trig_drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL sweep_drop got=%0d exp=0", trig_drop_cnt);
    end
  endtask

  // Random back-pressure plus a 7-cycle stall on idx 5.
  task automatic test_backpressure();
    int               exp_i;
    int               hold_cnt;
    logic             stall;
    logic             finished;
    logic [IDX_W+CNT_W+1:0] held;
    cfg_period    = '0;
    oif.out_ready = 1'b1;
    for (int k = 0; k < N_CNT; k++) mem[k] = CNT_W'(32'hDEAD_0000 + k);
    @(negedge clk);
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig  = 1'b0;
    exp_i    = 0;
    hold_cnt = 0;
    stall    = 1'b0;
    finished = 1'b0;
    held     = '0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      if (stall) begin
        checks++;
        if ({oif.out_valid, oif.out_idx, oif.out_data, oif.out_last} !== held) begin
          failures++;
          $display("FAIL bp_hold got=%h exp=%h",
                   {oif.out_valid, oif.out_idx, oif.out_data, oif.out_last}, held);
        end
      end
      if (oif.out_valid) begin
        if (oif.out_idx == IDX_W'(5) && hold_cnt < 7) begin
          oif.out_ready = 1'b0;
          hold_cnt++;
        end else begin
          oif.out_ready = ($urandom_range(0, 3) != 0);
        end
        if (oif.out_ready) begin
          checks++;
          if ({oif.out_idx, oif.out_data, oif.out_last} !==
              {IDX_W'(exp_i), CNT_W'(32'hDEAD_0000 + exp_i), exp_i == N_CNT - 1}) begin
            failures++;
            $display("FAIL bp_rec got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                     oif.out_idx, oif.out_data, oif.out_last,
                     exp_i, 32'hDEAD_0000 + exp_i, exp_i == N_CNT - 1);
          end
          exp_i++;
          if (exp_i == N_CNT) finished = 1'b1;
        end
        stall = !oif.out_ready;
        held  = {1'b1, oif.out_idx, oif.out_data, oif.out_last};
      end else begin
        oif.out_ready = 1'($urandom_range(0, 1));
        stall         = 1'b0;
      end
    end
    checks++;
    if (exp_i != N_CNT || hold_cnt != 7) begin
      failures++;
      $display("FAIL bp_complete got records=%0d stalls=%0d exp records=%0d stalls=7",
               exp_i, hold_cnt, N_CNT);
    end
    oif.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b11) begin
      failures++;
      $display("FAIL bp_done got done,busy=%b exp=11", {done, busy});
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL bp_idle got done,busy=%b exp=00", {done, busy});
    end
  endtask

  // Timer-driven sweeps; sw_at is the edge index of an extra software trigger (-1 none).
  task automatic test_timer(input int period, input int ncyc, input logic clear, input int sw_at);
    int   k_last;
    int   drops;
    logic fire;
    logic snap_exp;
    logic busy_exp;
    k_last            = -100000;
    drops             = 0;
    cfg_period        = TMR_W'(period);
    cfg_clear_on_snap = clear;
    oif.out_ready     = 1'b1;
    do_reset();
    sw_trig = (sw_at == 0);
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      fire     = ((j + 1) % period == 0);
      snap_exp = 1'b0;
      if (fire || j == sw_at) begin
        if (j > k_last + D + 1) begin
          k_last   = j;
          snap_exp = 1'b1;
        end else if (drops < 255) begin
          drops++;
        end
      end
      busy_exp = (j >= k_last) && (j <= k_last + D);
      checks++;
      if ({sa_snap, sa_clear_live, busy, trig_drop_cnt} !==
          {snap_exp, snap_exp & clear, busy_exp, 8'(drops)}) begin
        failures++;
        $display("FAIL tmr p=%0d j=%0d got snap=%b clr=%b busy=%b drop=%0d exp snap=%b clr=%b busy=%b drop=%0d",
                 period, j, sa_snap, sa_clear_live, busy, trig_drop_cnt,
                 snap_exp, snap_exp & clear, busy_exp, drops);
      end
      sw_trig = (j + 1 == sw_at);
    end
    sw_trig           = 1'b0;
    cfg_period        = '0;
    cfg_clear_on_snap = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid_sweep();
    logic found;
    cfg_period    = '0;
    oif.out_ready = 1'b1;
    @(negedge clk);
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (oif.out_valid && oif.out_idx == IDX_W'(30)) begin
        oif.out_ready = 1'b0;
        found         = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_mid_reach got=no idx30 record exp=idx30 record");
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({oif.out_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid_abort got valid,busy,done=%b exp=000", {oif.out_valid, busy, done});
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({oif.out_valid, busy, done} !== 3'b000) begin
        failures++;
        $display("FAIL rst_mid_quiet c=%0d got valid,busy,done=%b exp=000", c,
                 {oif.out_valid, busy, done});
      end
    end
    test_sw_sweep(1'b0);
  endtask

  initial begin
    rst               = 1'b1;
    sw_trig           = 1'b0;
    cfg_period        = '0;
    cfg_clear_on_snap = 1'b0;
    oif.out_ready     = 1'b0;
    for (int k = 0; k < N_CNT; k++) mem[k] = '0;

    test_reset();
    test_sw_sweep(1'b0);
    test_sw_sweep(1'b1);
    test_backpressure();
    test_timer(250, 800, 1'b0, -1);
    test_timer(100, 500, 1'b0, -1);
    test_timer(10, 4200, 1'b0, -1);
    test_timer(10, 60, 1'b1, 9);
    test_timer(1, 300, 1'b0, -1);
    test_reset_mid_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
